// File: rtl/nios2_cpu_debug_ocimem_if.sv
// CPU-side Avalon-MM port onto the OCI debug RAM, shared by the CPU master and the OCI memory slave.
interface nios2_cpu_debug_ocimem_if #(
   parameter int ADDR_W = 8
) ();
   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [31:0]       writedata;
   logic [3:0]        byteenable;
   logic              debugaccess;
   logic              waitrequest;
   logic [31:0]       readdata;

   modport master (
      output address, read, write, writedata, byteenable, debugaccess,
      input  waitrequest, readdata
   );

   modport slave (
      input  address, read, write, writedata, byteenable, debugaccess,
      output waitrequest, readdata
   );
endinterface

// File: rtl/nios2_cpu_debug_ocimem.sv
// OCI debug memory: executes JTAG debug-slave read/write commands on a single-port RAM
// and arbitrates the CPU Avalon-MM port onto the same RAM, with JTAG taking priority.
module nios2_cpu_debug_ocimem #(
   parameter int ADDR_W = 8
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [37:0]                 jdo,
   input  logic                        take_action_ocimem_a,
   input  logic                        take_no_action_ocimem_a,
   input  logic                        take_action_ocimem_b,
   nios2_cpu_debug_ocimem_if.slave     avs,
   output logic [31:0]                 MonDReg,
   output logic                        monitor_ready,
   output logic                        monitor_error
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_JRD  = 3'd1;
   localparam logic [2:0] ST_JCAP = 3'd2;
   localparam logic [2:0] ST_JWR  = 3'd3;
   localparam logic [2:0] ST_CRD  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] monAReg_q, monAReg_d;
   logic [31:0]       monDReg_q, monDReg_d;
   logic              ready_q, ready_d;
   logic              error_q, error_d;
   logic [31:0]       readdata_q, readdata_d;

   logic [31:0]       mem [0:(1<<ADDR_W)-1];
   logic [31:0]       ramQ;
   logic [ADDR_W-1:0] ramAddr;
   logic [31:0]       ramWData;
   logic [3:0]        ramBe;
   logic              ramWe;

   logic inIdle, anyPulse, jtagBusy;
   logic acceptB, acceptA, acceptNa, dropPulse;
   logic cpuWriteGo, readDone;
   logic unusedJdo;

   assign unusedJdo = ^jdo[37:36];

   // Pulses are only honoured in IDLE; any pulse that loses arbitration is recorded as an error.
   always_comb begin
      inIdle    = (state_q == ST_IDLE);
      anyPulse  = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
      jtagBusy  = (state_q == ST_JRD) | (state_q == ST_JCAP) | (state_q == ST_JWR);
      acceptB   = inIdle & take_action_ocimem_b;
      acceptA   = inIdle & take_action_ocimem_a & ~take_action_ocimem_b;
      acceptNa  = inIdle & take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
      dropPulse = inIdle ? ((take_action_ocimem_b & (take_action_ocimem_a | take_no_action_ocimem_a)) |
                            (take_action_ocimem_a & take_no_action_ocimem_a))
                         : anyPulse;
      avs.waitrequest = (avs.read | avs.write) &
                        (jtagBusy | anyPulse | (avs.read & (state_q != ST_CRD)));
      cpuWriteGo = avs.write & ~avs.read & ~jtagBusy & ~anyPulse;
      readDone   = avs.read & (state_q == ST_CRD) & ~anyPulse;
   end

   always_comb begin
      state_d    = state_q;
      monAReg_d  = monAReg_q;
      monDReg_d  = monDReg_q;
      ready_d    = ready_q;
      error_d    = error_q;
      readdata_d = readdata_q;
      case (state_q)
         ST_IDLE: begin
            if (acceptB) begin
               monDReg_d = jdo[34:3];
               ready_d   = 1'b0;
               state_d   = ST_JWR;
            end else if (acceptA) begin
               monAReg_d = jdo[ADDR_W+16:17];
               ready_d   = ~jdo[35];
               error_d   = 1'b0;
               state_d   = jdo[35] ? ST_JRD : ST_IDLE;
            end else if (acceptNa) begin
               monAReg_d = monAReg_q + ADDR_W'(1);
               ready_d   = 1'b0;
               state_d   = ST_JRD;
            end else if (avs.read) begin
               state_d = ST_CRD;
            end
         end
         ST_JRD:  state_d = ST_JCAP;
         ST_JCAP: begin
            monDReg_d = ramQ;
            ready_d   = 1'b1;
            state_d   = ST_IDLE;
         end
         ST_JWR: begin
            monAReg_d = monAReg_q + ADDR_W'(1);
            ready_d   = 1'b1;
            state_d   = ST_IDLE;
         end
         ST_CRD: begin
            if (readDone) readdata_d = ramQ;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (dropPulse) error_d = 1'b1;
   end

   // RAM port steering: JTAG owns the address while it is reading or writing.
   always_comb begin
      if ((state_q == ST_JRD) || (state_q == ST_JWR)) begin
         ramAddr = monAReg_q;
      end else begin
         ramAddr = avs.address;
      end
      ramWData = (state_q == ST_JWR) ? monDReg_q : avs.writedata;
      ramBe    = (state_q == ST_JWR) ? 4'hF : avs.byteenable;
      ramWe    = reset_n & ((state_q == ST_JWR) | (cpuWriteGo & avs.debugaccess));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         monAReg_q  <= '0;
         monDReg_q  <= '0;
         ready_q    <= 1'b0;
         error_q    <= 1'b0;
         readdata_q <= '0;
      end else begin
         state_q    <= state_d;
         monAReg_q  <= monAReg_d;
         monDReg_q  <= monDReg_d;
         ready_q    <= ready_d;
         error_q    <= error_d;
         readdata_q <= readdata_d;
      end
   end

   // Contents are deliberately not reset; read data appears one cycle after the address.
   always_ff @(posedge clk) begin
      if (ramWe) begin
         for (int b = 0; b < 4; b++) begin
            if (ramBe[b]) mem[ramAddr][8*b +: 8] <= ramWData[8*b +: 8];
         end
      end
      ramQ <= mem[ramAddr];
   end

   assign avs.readdata  = (state_q == ST_CRD) ? ramQ : readdata_q;
   assign MonDReg       = monDReg_q;
   assign monitor_ready = ready_q;
   assign monitor_error = error_q;

endmodule

// File: tb/tb_nios2_cpu_debug_ocimem.sv
// Randomised and directed bench for the OCI debug memory against a word-level memory model.
module tb_nios2_cpu_debug_ocimem;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [37:0] jdo = '0;
   logic        actA = 1'b0, noActA = 1'b0, actB = 1'b0;
   logic [31:0] MonDReg;
   logic        monitor_ready, monitor_error;

   nios2_cpu_debug_ocimem_if #(.ADDR_W(ADDR_W)) avs ();

   nios2_cpu_debug_ocimem #(.ADDR_W(ADDR_W)) dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .jdo                     (jdo),
      .take_action_ocimem_a    (actA),
      .take_no_action_ocimem_a (noActA),
      .take_action_ocimem_b    (actB),
      .avs                     (avs),
      .MonDReg                 (MonDReg),
      .monitor_ready           (monitor_ready),
      .monitor_error           (monitor_error)
   );

   always #5 clk = ~clk;

   // Reference model: memory words, debugger address pointer and data register.
   logic [31:0] modelMem [DEPTH];
   int          modelAddr;
   logic [31:0] modelD;
   int          testsRun = 0;
   int          testsFailed = 0;

   function automatic logic [37:0] jdoAddr(input logic [7:0] a, input logic rd);
      logic [37:0] j;
      j = '0;
      j[24:17] = a;
      j[35] = rd;
      return j;
   endfunction

   function automatic logic [37:0] jdoData(input logic [31:0] d);
      logic [37:0] j;
      j = '0;
      j[34:3] = d;
      return j;
   endfunction

   task automatic pulse(input int kind, input logic [37:0] j);
      @(negedge clk);
      jdo = j;
      if (kind == 0) actA = 1'b1;
      if (kind == 1) noActA = 1'b1;
      if (kind == 2) actB = 1'b1;
      @(negedge clk);
      actA = 1'b0; noActA = 1'b0; actB = 1'b0;
   endtask

   task automatic jtagSetAddr(input logic [7:0] a, input logic rd);
      pulse(0, jdoAddr(a, rd));
      modelAddr = a;
      if (rd) begin
         repeat (2) @(negedge clk);
         modelD = modelMem[a];
      end
   endtask

   task automatic jtagWrite(input logic [31:0] d);
      pulse(2, jdoData(d));
      @(negedge clk);
      modelMem[modelAddr] = d;
      modelD = d;
      modelAddr = (modelAddr + 1) % DEPTH;
   endtask

   task automatic jtagNext;
      pulse(1, '0);
      repeat (2) @(negedge clk);
      modelAddr = (modelAddr + 1) % DEPTH;
      modelD = modelMem[modelAddr];
   endtask

   task automatic cpuWrite(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                           input logic dbg, output logic waitSeen);
      @(negedge clk);
      avs.address = a; avs.writedata = d; avs.byteenable = be; avs.debugaccess = dbg;
      avs.write = 1'b1;
      #1 waitSeen = avs.waitrequest;
      @(negedge clk);
      avs.write = 1'b0;
      if (dbg) begin
         for (int b = 0; b < 4; b++) if (be[b]) modelMem[a][8*b +: 8] = d[8*b +: 8];
      end
   endtask

   task automatic cpuRead(input logic [7:0] a, output logic [31:0] data, output int cycles,
                          output logic ok);
      @(negedge clk);
      avs.address = a;
      avs.read = 1'b1;
      cycles = 0;
      ok = 1'b0;
      data = '0;
      for (int i = 0; i < 20 && !ok; i++) begin
         #1;
         if (!avs.waitrequest) begin
            data = avs.readdata;
            ok = 1'b1;
         end else begin
            @(negedge clk);
            cycles++;
         end
      end
      @(negedge clk);
      avs.read = 1'b0;
   endtask

   task automatic test_reset;
      #1;
      testsRun++;
      if (MonDReg !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_MonDReg got %h want 0", MonDReg); end
      testsRun++;
      if (monitor_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ready got %b want 0", monitor_ready); end
      testsRun++;
      if (monitor_error !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_error got %b want 0", monitor_error); end
      testsRun++;
      if (avs.waitrequest !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_wait got %b want 0", avs.waitrequest); end
      testsRun++;
      if (avs.readdata !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_readdata got %h want 0", avs.readdata); end
   endtask

   task automatic fill_memory;
      logic w;
      for (int i = 0; i < DEPTH; i++) cpuWrite(8'(i), $urandom, 4'hF, 1'b1, w);
   endtask

   task automatic test_jtag_write_read;
      jtagSetAddr(8'h10, 1'b0);
      testsRun++;
      if (monitor_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL seta_ready got %b want 1", monitor_ready); end
      pulse(2, jdoData(32'hDEADBEEF));
      testsRun++;
      if (monitor_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL wr_ready_early got %b want 0", monitor_ready); end
      @(negedge clk);
      modelMem[8'h10] = 32'hDEADBEEF; modelD = 32'hDEADBEEF; modelAddr = 8'h11;
      testsRun++;
      if (monitor_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL wr_ready got %b want 1", monitor_ready); end
      jtagNext;
      testsRun++;
      if (MonDReg !== modelMem[8'h12]) begin testsFailed++; $display("[TB] FAIL post_wr_addr got %h want %h", MonDReg, modelMem[8'h12]); end
      pulse(0, jdoAddr(8'h10, 1'b1));
      modelAddr = 8'h10;
      testsRun++;
      if (monitor_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL rd_ready_c1 got %b want 0", monitor_ready); end
      @(negedge clk);
      testsRun++;
      if (monitor_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL rd_ready_c2 got %b want 0", monitor_ready); end
      @(negedge clk);
      modelD = modelMem[8'h10];
      testsRun++;
      if (monitor_ready !== 1'b1 || MonDReg !== 32'hDEADBEEF) begin
         testsFailed++; $display("[TB] FAIL rd_data got %b/%h want 1/deadbeef", monitor_ready, MonDReg);
      end
   endtask

   task automatic test_wrap;
      jtagSetAddr(8'hFF, 1'b0);
      jtagNext;
      testsRun++;
      if (MonDReg !== modelMem[0]) begin testsFailed++; $display("[TB] FAIL wrap_data got %h want %h", MonDReg, modelMem[0]); end
      testsRun++;
      if (monitor_error !== 1'b0) begin testsFailed++; $display("[TB] FAIL wrap_error got %b want 0", monitor_error); end
   endtask

   task automatic test_dropped_pulse;
      logic [31:0] d;
      int cyc;
      logic ok;
      pulse(0, jdoAddr(8'h20, 1'b1));
      jdo = jdoData(32'hCAFEF00D);
      actB = 1'b1;
      @(negedge clk);
      actB = 1'b0;
      @(negedge clk);
      modelAddr = 8'h20; modelD = modelMem[8'h20];
      testsRun++;
      if (monitor_error !== 1'b1) begin testsFailed++; $display("[TB] FAIL drop_error got %b want 1", monitor_error); end
      testsRun++;
      if (MonDReg !== modelD) begin testsFailed++; $display("[TB] FAIL drop_read got %h want %h", MonDReg, modelD); end
      cpuRead(8'h20, d, cyc, ok);
      testsRun++;
      if (!ok || d !== modelMem[8'h20]) begin testsFailed++; $display("[TB] FAIL drop_ram20 got %h want %h", d, modelMem[8'h20]); end
      cpuRead(8'h21, d, cyc, ok);
      testsRun++;
      if (!ok || d !== modelMem[8'h21]) begin testsFailed++; $display("[TB] FAIL drop_ram21 got %h want %h", d, modelMem[8'h21]); end
      jtagSetAddr(8'h30, 1'b0);
      testsRun++;
      if (monitor_error !== 1'b0) begin testsFailed++; $display("[TB] FAIL drop_clear got %b want 0", monitor_error); end
   endtask

   task automatic test_priority;
      logic [31:0] d;
      int cyc;
      logic ok;
      @(negedge clk);
      jdo = jdoData(32'h5A5AA5A5);
      actA = 1'b1; actB = 1'b1;
      @(negedge clk);
      actA = 1'b0; actB = 1'b0;
      @(negedge clk);
      modelMem[modelAddr] = 32'h5A5AA5A5;
      testsRun++;
      if (monitor_error !== 1'b1) begin testsFailed++; $display("[TB] FAIL prio_error got %b want 1", monitor_error); end
      cpuRead(8'h30, d, cyc, ok);
      testsRun++;
      if (!ok || d !== 32'h5A5AA5A5) begin testsFailed++; $display("[TB] FAIL prio_write got %h want 5a5aa5a5", d); end
      modelAddr = 8'h31; modelD = 32'h5A5AA5A5;
      jtagSetAddr(8'h30, 1'b0);
   endtask

   task automatic test_cpu_read_stall;
      logic [31:0] d;
      int cyc;
      logic ok;
      @(negedge clk);
      jdo = jdoAddr(8'h40, 1'b1);
      actA = 1'b1;
      avs.address = 8'h10;
      avs.read = 1'b1;
      cyc = 0; ok = 1'b0; d = '0;
      for (int i = 0; i < 20 && !ok; i++) begin
         #1;
         if (!avs.waitrequest) begin
            d = avs.readdata;
            ok = 1'b1;
         end else begin
            @(negedge clk);
            actA = 1'b0;
            cyc++;
         end
      end
      @(negedge clk);
      avs.read = 1'b0;
      modelAddr = 8'h40; modelD = modelMem[8'h40];
      testsRun++;
      if (!ok || cyc != 4) begin testsFailed++; $display("[TB] FAIL stall_cycles got %0d want 4", cyc); end
      testsRun++;
      if (d !== 32'hDEADBEEF) begin testsFailed++; $display("[TB] FAIL stall_data got %h want deadbeef", d); end
      testsRun++;
      if (MonDReg !== modelD) begin testsFailed++; $display("[TB] FAIL stall_jtag got %h want %h", MonDReg, modelD); end
      jtagNext;
      testsRun++;
      if (avs.readdata !== 32'hDEADBEEF) begin testsFailed++; $display("[TB] FAIL readdata_hold got %h want deadbeef", avs.readdata); end
   endtask

   task automatic test_cpu_write_mask;
      logic [31:0] d, old;
      int cyc;
      logic ok, w;
      old = modelMem[8'h44];
      cpuWrite(8'h44, 32'h12345678, 4'b0011, 1'b0, w);
      testsRun++;
      if (w !== 1'b0) begin testsFailed++; $display("[TB] FAIL nodbg_wait got %b want 0", w); end
      cpuRead(8'h44, d, cyc, ok);
      testsRun++;
      if (!ok || d !== old) begin testsFailed++; $display("[TB] FAIL nodbg_ram got %h want %h", d, old); end
      cpuWrite(8'h44, 32'h12345678, 4'b0011, 1'b1, w);
      cpuRead(8'h44, d, cyc, ok);
      testsRun++;
      if (!ok || d !== {old[31:16], 16'h5678}) begin
         testsFailed++; $display("[TB] FAIL be_ram got %h want %h", d, {old[31:16], 16'h5678});
      end
   endtask

   task automatic test_reset_midop;
      logic [31:0] d;
      int cyc;
      logic ok;
      jtagSetAddr(8'h50, 1'b0);
      pulse(2, jdoData(32'h0BADF00D));
      reset_n = 1'b0;
      #2;
      testsRun++;
      if (MonDReg !== 32'h0 || monitor_ready !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL midrst_regs got %h/%b want 0/0", MonDReg, monitor_ready);
      end
      @(negedge clk);
      reset_n = 1'b1;
      modelAddr = 0; modelD = '0;
      cpuRead(8'h50, d, cyc, ok);
      testsRun++;
      if (!ok || d !== modelMem[8'h50]) begin testsFailed++; $display("[TB] FAIL midrst_ram got %h want %h", d, modelMem[8'h50]); end
      jtagNext;
      testsRun++;
      if (MonDReg !== modelMem[1]) begin testsFailed++; $display("[TB] FAIL midrst_addr got %h want %h", MonDReg, modelMem[1]); end
   endtask

   task automatic test_random;
      logic [31:0] d, r;
      logic [7:0]  a;
      int          cyc;
      logic        ok, w, rd;
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 4))
            0: begin
               a = 8'($urandom); rd = 1'($urandom);
               jtagSetAddr(a, rd);
               testsRun++;
               if (MonDReg !== modelD || monitor_ready !== 1'b1) begin
                  testsFailed++; $display("[TB] FAIL rnd_seta got %h/%b want %h/1", MonDReg, monitor_ready, modelD);
               end
            end
            1: begin
               d = $urandom;
               jtagWrite(d);
               testsRun++;
               if (MonDReg !== d || monitor_ready !== 1'b1) begin
                  testsFailed++; $display("[TB] FAIL rnd_jwr got %h/%b want %h/1", MonDReg, monitor_ready, d);
               end
            end
            2: begin
               jtagNext;
               testsRun++;
               if (MonDReg !== modelD) begin testsFailed++; $display("[TB] FAIL rnd_next got %h want %h", MonDReg, modelD); end
            end
            3: begin
               cpuWrite(8'($urandom), $urandom, 4'($urandom), 1'($urandom), w);
               testsRun++;
               if (w !== 1'b0) begin testsFailed++; $display("[TB] FAIL rnd_cwr_wait got %b want 0", w); end
            end
            default: begin
               a = 8'($urandom);
               cpuRead(a, r, cyc, ok);
               testsRun++;
               if (!ok || r !== modelMem[a]) begin testsFailed++; $display("[TB] FAIL rnd_crd got %h want %h", r, modelMem[a]); end
            end
         endcase
      end
      testsRun++;
      if (monitor_error !== 1'b0) begin testsFailed++; $display("[TB] FAIL rnd_error got %b want 0", monitor_error); end
   endtask

   initial begin
      avs.address = '0; avs.read = 1'b0; avs.write = 1'b0; avs.writedata = '0;
      avs.byteenable = '0; avs.debugaccess = 1'b0;
      modelAddr = 0; modelD = '0;
      repeat (3) @(negedge clk);
      test_reset;
      reset_n = 1'b1;
      fill_memory;
      test_jtag_write_read;
      test_wrap;
      test_dropped_pulse;
      test_priority;
      test_cpu_read_stall;
      test_cpu_write_mask;
      test_reset_midop;
      test_random;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired after %0d tests", testsRun);
      $fatal(1, "[TB] timeout");
   end

endmodule
